// File: rtl/hwpe_stream_tcdm_responder_pkg.sv
// Shared types and constants for the TCDM responder.
// TCDM request/response bundles are carried as packed structs, one element per channel.
package hwpe_stream_tcdm_responder_pkg;

   localparam int unsigned TCDM_RESP_LATENCY = 1;

   // Stall generator used when HWPE_TCDM_RESPONDER_STALL_EN is defined
   localparam logic [15:0] LFSR_POLY = 16'hB400;
   localparam logic [15:0] LFSR_SEED = 16'hACE1;

   typedef struct packed {
      logic        req;
      logic [31:0] add;
      logic        wen;
      logic [3:0]  be;
      logic [31:0] data;
   } tcdm_req_t;

   typedef struct packed {
      logic        gnt;
      logic [31:0] r_data;
      logic        r_valid;
   } tcdm_resp_t;

   // One step of the right-shifting Galois LFSR
   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
   endfunction

endpackage

// File: rtl/hwpe_stream_tcdm_rr_arbiter.sv
// Round-robin arbiter for one bank: combinational one-hot grant, registered rotating pointer.
// The pointer moves to winner+1 only on cycles where a grant is actually issued.
module hwpe_stream_tcdm_rr_arbiter #(
   parameter int unsigned NB_REQ = 4,
   localparam int unsigned IW    = (NB_REQ > 1) ? $clog2(NB_REQ) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              en,
   input  logic [NB_REQ-1:0] req,
   output logic [NB_REQ-1:0] gnt,
   output logic [IW-1:0]     win,
   output logic              valid,
   output logic [IW-1:0]     rr
);

   logic [IW-1:0] rr_q, rr_d;
   logic [IW-1:0] cand;
   logic          found;

   always_comb begin
      gnt   = '0;
      win   = '0;
      found = 1'b0;
      cand  = '0;
      rr_d  = rr_q;
      // Scan upward from the pointer with wrap; first requester wins
      for (int unsigned k = 0; k < NB_REQ; k++) begin
         cand = IW'((32'(rr_q) + k) % NB_REQ);
         if (!found && req[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
      if (en && found) begin
         gnt[win] = 1'b1;
         rr_d     = (32'(win) == NB_REQ - 1) ? '0 : win + 1'b1;
      end
   end

   assign valid = found & en;
   assign rr    = rr_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_q <= '0;
      end else if (clear) begin
         rr_q <= '0;
      end else begin
         rr_q <= rr_d;
      end
   end

endmodule

// File: rtl/hwpe_stream_tcdm_responder.sv
// Memory-side TCDM responder: NB_CHAN slave ports onto NB_BANKS word-interleaved banks,
// single-cycle grant, response one cycle later. Optional grant stalls: HWPE_TCDM_RESPONDER_STALL_EN.
module hwpe_stream_tcdm_responder
   import hwpe_stream_tcdm_responder_pkg::*;
#(
   parameter int unsigned NB_CHAN    = 4,
   parameter int unsigned NB_BANKS   = 4,
   parameter int unsigned BANK_DEPTH = 256
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      clear_i,
   input  tcdm_req_t  [NB_CHAN-1:0]  tcdm_req,
   output tcdm_resp_t [NB_CHAN-1:0]  tcdm_resp
);

   localparam int unsigned BANK_AW = $clog2(NB_BANKS);
   localparam int unsigned BW      = (NB_BANKS > 1) ? BANK_AW : 1;
   localparam int unsigned ROW_AW  = $clog2(BANK_DEPTH);
   localparam int unsigned RW      = (ROW_AW > 0) ? ROW_AW : 1;
   localparam int unsigned CW      = (NB_CHAN > 1) ? $clog2(NB_CHAN) : 1;

   logic [NB_CHAN-1:0][BW-1:0]       bank_sel;
   logic [NB_CHAN-1:0][RW-1:0]       row_sel;
   logic [NB_BANKS-1:0][NB_CHAN-1:0] bank_req;
   logic [NB_BANKS-1:0][NB_CHAN-1:0] bank_gnt;
   logic [NB_BANKS-1:0][31:0]        bank_rdata;
   logic [NB_BANKS-1:0][CW-1:0]      rr_ptr;
   logic [NB_BANKS-1:0]              bank_en;
   logic [NB_CHAN-1:0]               gnt;
   logic [NB_CHAN-1:0][31:0]         rdata_d, rdata_q;
   logic [NB_CHAN-1:0]               rvalid_q;

   // Address decode: word offset ignored, upper bits alias
   always_comb begin
      bank_sel = '0;
      row_sel  = '0;
      for (int unsigned c = 0; c < NB_CHAN; c++) begin
         if (NB_BANKS > 1) begin
            bank_sel[c] = tcdm_req[c].add[2 +: BW];
         end
         row_sel[c] = tcdm_req[c].add[2 + BANK_AW +: RW];
      end
   end

   always_comb begin
      bank_req = '0;
      for (int unsigned b = 0; b < NB_BANKS; b++) begin
         for (int unsigned c = 0; c < NB_CHAN; c++) begin
            bank_req[b][c] = tcdm_req[c].req && (32'(bank_sel[c]) == b);
         end
      end
   end

`ifdef HWPE_TCDM_RESPONDER_STALL_EN
   logic [15:0] lfsr_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         lfsr_q <= LFSR_SEED;
      end else if (clear_i) begin
         lfsr_q <= LFSR_SEED;
      end else begin
         lfsr_q <= lfsr_next(lfsr_q);
      end
   end

   always_comb begin
      bank_en = '0;
      for (int unsigned b = 0; b < NB_BANKS; b++) begin
         bank_en[b] = !clear_i && !lfsr_q[4'(b % 16)];
      end
   end
`else
   assign bank_en = {NB_BANKS{!clear_i}};
`endif

   for (genvar b = 0; b < NB_BANKS; b++) begin : gen_bank
      logic [CW-1:0] win;
      logic          bank_valid;
      tcdm_req_t     win_req;
      logic [RW-1:0] win_row;
      logic [31:0]   mem_q [BANK_DEPTH];

      hwpe_stream_tcdm_rr_arbiter #(
         .NB_REQ (NB_CHAN)
      ) i_arb (
         .clk   (clk_i),
         .rst_n (rst_ni),
         .clear (clear_i),
         .en    (bank_en[b]),
         .req   (bank_req[b]),
         .gnt   (bank_gnt[b]),
         .win   (win),
         .valid (bank_valid),
         .rr    (rr_ptr[b])
      );

      assign win_req = tcdm_req[win];
      assign win_row = row_sel[win];

      // Contents are deliberately not reset; writes are blocked while reset is held
      always_ff @(posedge clk_i) begin
         if (rst_ni && bank_valid && !win_req.wen) begin
            for (int k = 0; k < 4; k++) begin
               if (win_req.be[k]) begin
                  mem_q[win_row][8*k +: 8] <= win_req.data[8*k +: 8];
               end
            end
         end
      end

      // Read-before-write: the granted read sees the pre-edge row content
      assign bank_rdata[b] = mem_q[win_row];
   end

   always_comb begin
      gnt = '0;
      for (int unsigned b = 0; b < NB_BANKS; b++) begin
         gnt |= bank_gnt[b];
      end
   end

   always_comb begin
      rdata_d = '0;
      for (int unsigned c = 0; c < NB_CHAN; c++) begin
         if (gnt[c] && tcdm_req[c].wen) begin
            rdata_d[c] = bank_rdata[bank_sel[c]];
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rvalid_q <= '0;
         rdata_q  <= '0;
      end else if (clear_i) begin
         rvalid_q <= '0;
         rdata_q  <= '0;
      end else begin
         rvalid_q <= gnt;
         rdata_q  <= rdata_d;
      end
   end

   // A response landing in a clear cycle is dropped at the port
   always_comb begin
      tcdm_resp = '0;
      for (int unsigned c = 0; c < NB_CHAN; c++) begin
         tcdm_resp[c].gnt     = gnt[c];
         tcdm_resp[c].r_valid = rvalid_q[c] && !clear_i;
         tcdm_resp[c].r_data  = clear_i ? 32'h0 : rdata_q[c];
      end
   end

   logic unused_sig;
   assign unused_sig = ^{rr_ptr, tcdm_req};

endmodule

// File: tb/tb_hwpe_stream_tcdm_responder.sv
// Directed bench for hwpe_stream_tcdm_responder (default build, no grant stalls).
module tb_hwpe_stream_tcdm_responder;
   import hwpe_stream_tcdm_responder_pkg::*;

   localparam int unsigned NB_CHAN = 4;

   logic                     clk = 1'b0;
   logic                     rst_n;
   logic                     clear;
   tcdm_req_t  [NB_CHAN-1:0] tcdm_req;
   tcdm_resp_t [NB_CHAN-1:0] tcdm_resp;
   logic [31:0]              gnt_v, rv_v;
   int unsigned              checks = 0;
   int unsigned              errors = 0;

   always #5 clk = ~clk;

   hwpe_stream_tcdm_responder #(
      .NB_CHAN    (NB_CHAN),
      .NB_BANKS   (4),
      .BANK_DEPTH (256)
   ) dut (
      .clk_i     (clk),
      .rst_ni    (rst_n),
      .clear_i   (clear),
      .tcdm_req  (tcdm_req),
      .tcdm_resp (tcdm_resp)
   );

   always_comb begin
      gnt_v = '0;
      rv_v  = '0;
      for (int c = 0; c < NB_CHAN; c++) begin
         gnt_v[c] = tcdm_resp[c].gnt;
         rv_v[c]  = tcdm_resp[c].r_valid;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] rd(input int c);
      return tcdm_resp[c].r_data;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int c, input logic [31:0] a, input logic w, input logic [3:0] b,
                        input logic [31:0] d);
      tcdm_req[c] = '{req: 1'b1, add: a, wen: w, be: b, data: d};
   endtask

   task automatic idle();
      tcdm_req = '0;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n    = 1'b0;
      clear    = 1'b0;
      tcdm_req = '0;
      tick();
      tick();
      chk("reset_rvalid", rv_v, 32'h0);
      chk("reset_gnt", gnt_v, 32'h0);
      for (int c = 0; c < NB_CHAN; c++) chk("reset_rdata", rd(c), 32'h0);
      rst_n = 1'b1;
      tick();

      // Single channel write then read
      drive(0, 32'h10, 1'b0, 4'hF, 32'hDEADBEEF);
      #1 chk("wr_gnt", gnt_v, 32'h1);
      tick();
      chk("wr_rvalid", rv_v, 32'h1);
      chk("wr_rdata", rd(0), 32'h0);
      drive(0, 32'h10, 1'b1, 4'hF, 32'h0);
      #1 chk("rd_gnt", gnt_v, 32'h1);
      tick();
      chk("rd_rvalid", rv_v, 32'h1);
      chk("rd_rdata", rd(0), 32'hDEADBEEF);
      idle();
      tick();
      chk("idle_rvalid", rv_v, 32'h0);
      chk("idle_rdata", rd(0), 32'h0);

      // Byte enables
      drive(0, 32'h20, 1'b0, 4'hF, 32'h11223344);
      tick();
      drive(0, 32'h20, 1'b0, 4'b0101, 32'hAABBCCDD);
      tick();
      drive(0, 32'h20, 1'b1, 4'hF, 32'h0);
      tick();
      chk("be_rdata", rd(0), 32'h11BB33DD);
      idle();

      // Clear to zero the pointers, then four-way conflict on bank 0
      clear = 1'b1;
      tick();
      clear = 1'b0;
      for (int c = 0; c < NB_CHAN; c++) drive(c, 32'h10 * c, 1'b1, 4'hF, 32'h0);
      for (int i = 0; i < NB_CHAN; i++) begin
         #1 chk("rr_gnt", gnt_v, 32'(1) << i);
         tick();
         tcdm_req[i].req = 1'b0;
         chk("rr_rvalid", rv_v, 32'(1) << i);
         if (i == 1) chk("rr_rdata1", rd(1), 32'hDEADBEEF);
         if (i == 2) chk("rr_rdata2", rd(2), 32'h11BB33DD);
      end
      for (int c = 0; c < NB_CHAN; c++) drive(c, 32'h10 * c, 1'b1, 4'hF, 32'h0);
      #1 chk("rr_wrap_gnt", gnt_v, 32'h1);
      tick();
      chk("rr_wrap_rvalid", rv_v, 32'h1);
      idle();

      // Distinct banks: simultaneous writes then reads
      for (int c = 0; c < NB_CHAN; c++) drive(c, 32'h40 + 4 * c, 1'b0, 4'hF, 32'hC0DE0000 + c);
      #1 chk("par_wr_gnt", gnt_v, 32'hF);
      tick();
      chk("par_wr_rvalid", rv_v, 32'hF);
      for (int c = 0; c < NB_CHAN; c++) chk("par_wr_rdata", rd(c), 32'h0);
      for (int c = 0; c < NB_CHAN; c++) drive(c, 32'h40 + 4 * c, 1'b1, 4'hF, 32'h0);
      #1 chk("par_rd_gnt", gnt_v, 32'hF);
      tick();
      chk("par_rd_rvalid", rv_v, 32'hF);
      for (int c = 0; c < NB_CHAN; c++) chk("par_rd_rdata", rd(c), 32'hC0DE0000 + c);
      idle();

      // Aliasing: 0x1043 wraps onto bank 0 row 4
      drive(3, 32'h1043, 1'b1, 4'hF, 32'h0);
      #1 chk("alias_gnt", gnt_v, 32'h8);
      tick();
      chk("alias_rdata", rd(3), 32'hC0DE0000);
      idle();

      // Clear mid-stream
      drive(2, 32'h20, 1'b1, 4'hF, 32'h0);
      #1 chk("clr_pre_gnt", gnt_v, 32'h4);
      tick();
      clear = 1'b1;
      drive(2, 32'h10, 1'b1, 4'hF, 32'h0);
      drive(0, 32'h04, 1'b1, 4'hF, 32'h0);
      #1 chk("clr_gnt", gnt_v, 32'h0);
      chk("clr_rvalid", rv_v, 32'h0);
      chk("clr_rdata", rd(2), 32'h0);
      tick();
      clear = 1'b0;
      idle();
      chk("clr_post_rvalid", rv_v, 32'h0);
      drive(0, 32'h10, 1'b1, 4'hF, 32'h0);
      drive(3, 32'h20, 1'b1, 4'hF, 32'h0);
      #1 chk("clr_rr_gnt", gnt_v, 32'h1);
      tick();
      chk("clr_mem_rdata0", rd(0), 32'hDEADBEEF);
      tcdm_req[0].req = 1'b0;
      #1 chk("clr_next_gnt", gnt_v, 32'h8);
      tick();
      chk("clr_mem_rdata3", rd(3), 32'h11BB33DD);
      idle();

      // Async reset between grant and consumption of the response
      drive(1, 32'h10, 1'b1, 4'hF, 32'h0);
      #1 chk("rst_pre_gnt", gnt_v, 32'h2);
      tick();
      chk("rst_pre_rvalid", rv_v, 32'h2);
      #2 rst_n = 1'b0;
      #1 chk("rst_rvalid", rv_v, 32'h0);
      chk("rst_rdata", rd(1), 32'h0);
      idle();
      drive(0, 32'h10, 1'b0, 4'hF, 32'h0);
      #1 chk("rst_comb_gnt", gnt_v, 32'h1);
      tick();
      tick();
      idle();
      rst_n = 1'b1;
      drive(0, 32'h10, 1'b1, 4'hF, 32'h0);
      drive(2, 32'h20, 1'b1, 4'hF, 32'h0);
      #1 chk("rst_rr_gnt", gnt_v, 32'h1);
      tick();
      chk("rst_rvalid_after", rv_v, 32'h1);
      chk("rst_nowrite_rdata", rd(0), 32'hDEADBEEF);
      idle();
      tick();
      chk("end_rvalid", rv_v, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
